uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter core (clk-domain, start/busy interface) between NUM_REQ byte sources (echo path, status reporter, debug console, ...).
- Round-robin arbitration with packet lock: a granted source keeps the transmitter until its last byte, or until MAX_BURST bytes have gone out.
- Sits between the per-source valid/ready byte streams and the UART TX core.

---
 rtl/uart_pkg.sv | 6 +
 rtl/rr_pick.sv | 18 +
 rtl/uart_tx_arbiter.sv | 79 +++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and arbiter state encoding
package uart_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int CLKS_PER_BIT = 234;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first set request at or above ptr with wraparound
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    assign any = |req;
    // scanning offsets downward lets the smallest offset from ptr win
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX core between NUM_REQ byte sources
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 16,
    localparam int IW = $clog2(NUM_REQ),
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      grant_active,
    output logic [IW-1:0]             grant_id
);
    arb_state_t    state;
    logic [IW-1:0] rr_ptr, pick_idx, sel_id;
    logic [BW-1:0] burst_cnt;
    logic          last_flag, pick_any, done, issue;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .any(pick_any),
        .idx(pick_idx)
    );

    // a byte is launched either from a fresh pick or by continuing the held grant
    assign done   = last_flag || !req_valid[grant_id];
    assign issue  = (state == IDLE) ? pick_any : (state == WAIT_DONE && !tx_busy && !done);
    assign sel_id = (state == IDLE) ? pick_idx : grant_id;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            req_ready    <= '0;
            grant_active <= 1'b0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            last_flag    <= 1'b0;
        end else begin
            tx_start  <= issue;
            req_ready <= issue ? (NUM_REQ'(1) << sel_id) : '0;
            if (issue) tx_data <= req_data[int'(sel_id)*DATA_W +: DATA_W];
            case (state)
                IDLE: if (pick_any) begin
                    grant_id     <= pick_idx;
                    grant_active <= 1'b1;
                    burst_cnt    <= '0;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    burst_cnt <= burst_cnt + 1'b1;
                    last_flag <= req_last[grant_id] || (burst_cnt + 1'b1 == BW'(MAX_BURST));
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy) begin
                    state <= done ? IDLE : ISSUE;
                    if (done) begin
                        grant_active <= 1'b0;
                        rr_ptr       <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model
module tb_uart_tx_arbiter;
    localparam int N = 4, DW = 8, MB = 4;

    logic clk = 0, n_rst = 0, tx_busy = 0;
    logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic tx_start, grant_active;
    logic [DW-1:0] tx_data;
    logic [1:0] grant_id;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_active(grant_active), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // per-source pending bytes as {last, data}
    logic [8:0] q [N][$];
    int pass_cnt = 0, total = 0, cyc = 0, base = 0, t0 = 0;
    bit m_idle, m_cont, rel_pend, m_ga, m_last, arm, rnd_en;
    int holder, ptr, bcnt, busy_cnt, frame_len = 3;
    bit [N-1:0] pop_pend;
    logic [7:0] log_data[$];
    int log_id[$], log_cyc[$], log_ready[$];

    logic [7:0] rr_exp [5]    = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [7:0] lock_exp [4]  = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    logic [7:0] burst_exp [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h33, 8'h05, 8'h06};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endfunction

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int lget(int i, int kind);
        if (i >= log_data.size()) return -1;
        return kind == 0 ? int'(log_data[i]) : kind == 1 ? log_id[i] : kind == 2 ? log_cyc[i] : log_ready[i];
    endfunction

    function automatic void chk_log(string name, int i, logic [7:0] d);
        chk(name, lget(i, 0), {24'h0, d});
    endfunction

    function automatic bit q_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = q[i].size() > 0;
            req_last[i]          = req_valid[i] ? q[i][0][8] : 1'b0;
            req_data[i*DW +: DW] = req_valid[i] ? q[i][0][7:0] : '0;
        end
    endfunction

    function automatic void push_pkt(int i, int len);
        for (int b = 0; b < len; b++) q[i].push_back({b == len - 1, 8'($urandom)});
    endfunction

    function automatic void reset_on(bit flush);
        n_rst = 0; m_idle = 0; m_cont = 0; rel_pend = 0; m_ga = 0;
        arm = 0; busy_cnt = 0; tx_busy = 0; pop_pend = '0; ptr = 0;
        if (flush) for (int i = 0; i < N; i++) q[i].delete();
        drive();
    endfunction

    // one clock: compare outputs with the model, then advance sources and the TX core model
    task automatic cycle();
        logic [N-1:0] v;
        bit exp_start;
        @(negedge clk);
        cyc++;
        v = req_valid;
        exp_start = 0;
        if (m_idle && v != 0) begin
            holder = pick(v, ptr); bcnt = 0; m_idle = 0; m_ga = 1; exp_start = 1;
        end else if (m_cont) begin
            m_cont = 0; exp_start = 1;
        end
        chk("tx_start", tx_start, exp_start);
        chk("grant_active", grant_active, m_ga);
        if (m_ga) chk("grant_id", grant_id, holder);
        if (exp_start) begin
            chk("tx_data", tx_data, q[holder][0][7:0]);
            chk("req_ready", req_ready, 1 << holder);
            bcnt++;
            m_last = q[holder][0][8] || bcnt == MB;
        end else chk("req_ready", req_ready, 0);
        if (tx_start) begin
            log_data.push_back(tx_data); log_id.push_back(grant_id);
            log_cyc.push_back(cyc); log_ready.push_back(req_ready);
        end
        if (rel_pend) begin m_idle = 1; rel_pend = 0; end
        for (int i = 0; i < N; i++) if (pop_pend[i]) begin void'(q[i].pop_front()); pop_pend[i] = 0; end
        if (exp_start) pop_pend[holder] = 1;
        if (rnd_en) for (int i = 0; i < N; i++)
            if (q[i].size() == 0 && $urandom_range(0, 5) == 0) push_pkt(i, $urandom_range(1, 6));
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy = 0;
                if (m_last || q[holder].size() == 0) begin
                    rel_pend = 1; m_ga = 0; ptr = (holder + 1) % N;
                end else m_cont = 1;
            end
        end
        if (arm) begin tx_busy = 1; busy_cnt = rnd_en ? $urandom_range(1, 5) : frame_len; arm = 0; end
        if (tx_start) arm = 1;
        drive();
    endtask

    task automatic wait_log(int n);
        for (int t = 0; t < 3000 && log_data.size() < n; t++) cycle();
        if (log_data.size() < n) chk("frames_seen", log_data.size(), n);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int t = 0; t < 3000 && quiet < 3; t++) begin
            cycle();
            quiet = (!grant_active && !tx_busy && !arm && pop_pend == 0 && q_empty()) ? quiet + 1 : 0;
        end
        if (quiet < 3) chk("idle_timeout", quiet, 3);
    endtask

    initial begin
        for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'h10 + 8'(i)});
        drive();
        repeat (3) begin
            cycle();
            chk("rst_tx_start", tx_start, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_grant_active", grant_active, 0);
            chk("rst_grant_id", grant_id, 0);
        end
        n_rst = 1; m_idle = 1;
        wait_log(1);
        chk("first_grant_id", lget(0, 1), 0);
        q[0].push_back({1'b1, 8'h10}); drive();
        wait_log(5); wait_idle();
        for (int k = 0; k < 5; k++) chk_log("rr_order", k, rr_exp[k]);

        base = log_data.size();
        q[0].push_back({1'b1, 8'h55}); drive(); t0 = cyc;
        wait_log(base + 1); wait_idle();
        chk("single_latency", lget(base, 2) - t0, 1);
        chk("single_ready", lget(base, 3), 1);
        chk_log("single_data", base, 8'h55);
        chk("single_frames", log_data.size() - base, 1);
        chk("single_release", grant_active, 0);

        base = log_data.size();
        q[1].push_back({1'b0, 8'hA1}); q[1].push_back({1'b0, 8'hA2}); q[1].push_back({1'b1, 8'hA3});
        q[2].push_back({1'b1, 8'hB0}); drive();
        wait_log(base + 4); wait_idle();
        for (int k = 0; k < 4; k++) chk_log("lock_order", base + k, lock_exp[k]);
        for (int k = 0; k < 3; k++) chk("lock_grant_id", lget(base + k, 1), 1);

        base = log_data.size();
        for (int b = 1; b <= 6; b++) q[0].push_back({1'b0, 8'(b)});
        drive();
        wait_log(base + 1);
        q[3].push_back({1'b1, 8'h33}); drive();
        wait_log(base + 7); wait_idle();
        for (int k = 0; k < 7; k++) chk_log("burst_order", base + k, burst_exp[k]);

        base = log_data.size();
        q[2].push_back({1'b0, 8'hE1}); q[2].push_back({1'b0, 8'hE2}); q[2].push_back({1'b1, 8'hE3});
        drive();
        for (int t = 0; t < 200 && !(log_data.size() == base + 2 && tx_busy); t++) cycle();
        cycle();
        reset_on(1);
        cycle();
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_grant_active", grant_active, 0);
        chk("midrst_grant_id", grant_id, 0);
        cycle();
        q[0].push_back({1'b1, 8'hC0}); q[3].push_back({1'b1, 8'hC3}); drive();
        n_rst = 1; m_idle = 1;
        wait_log(base + 4); wait_idle();
        chk_log("post_reset_first", base + 2, 8'hC0);
        chk("post_reset_id", lget(base + 2, 1), 0);
        chk_log("post_reset_second", base + 3, 8'hC3);

        rnd_en = 1;
        repeat (4000) cycle();
        rnd_en = 0;
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
